result_wb_arbiter: RTL and testbench

- Sits directly downstream of conv_pool and consumes its three write streams (output_we_x / output_addr_x / y_x, x = 0..2).
- Merges the three streams into one single-port result memory write interface.
- Each channel has a small FIFO; a round-robin arbiter drains the FIFOs through one registered valid/ready write port.
- The channel index is prepended to the address, so all three feature maps share one physical memory.

---
 rtl/conv_pool_pkg.sv | 18 +
 rtl/result_wb_arbiter_wb_fifo.sv | 55 +++++
 rtl/result_wb_arbiter.sv | 118 +++++++++++
 tb/tb_result_wb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pool_pkg.sv
// Shared types for the conv_pool result write-back path.
package conv_pool_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int NUM_CH = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef logic [1:0] ch_idx_t;

  // Channel index successor, modulo the three kernels.
  function automatic ch_idx_t rr_next(input ch_idx_t c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction
endpackage

// File: rtl/result_wb_arbiter_wb_fifo.sv
// Per-channel synchronous FIFO; pushes into a full FIFO are dropped unless a pop frees a slot on the same edge.
module wb_fifo
  import conv_pool_pkg::*;
#(
  parameter int  FIFO_DEPTH = 4,
  parameter type entry_t    = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t head,
  output logic   full,
  output logic   empty,
  output logic   drop
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/result_wb_arbiter.sv
// Merges the three conv_pool result streams into one valid/ready memory write port
// through per-channel FIFOs and a round-robin arbiter.
module result_wb_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_we_0,
  input  logic              in_we_1,
  input  logic              in_we_2,
  input  logic [ADDR_W-1:0] in_addr_0,
  input  logic [ADDR_W-1:0] in_addr_1,
  input  logic [ADDR_W-1:0] in_addr_2,
  input  logic [DATA_W-1:0] in_data_0,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W+1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [NUM_CH-1:0] fifo_full,
  output logic [NUM_CH-1:0] overflow,
  output logic              idle
);
  import conv_pool_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            wdata [NUM_CH];
  entry_t            head  [NUM_CH];
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] drop;

  ch_idx_t           rr;
  ch_idx_t           grant;
  logic              load;

  logic              vld_p0;
  logic [ADDR_W+1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  assign push     = {in_we_2, in_we_1, in_we_0};
  assign wdata[0] = '{addr: in_addr_0, data: in_data_0};
  assign wdata[1] = '{addr: in_addr_1, data: in_data_1};
  assign wdata[2] = '{addr: in_addr_2, data: in_data_2};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    wb_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .entry_t   (entry_t)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[g]),
      .pop  (pop[g]),
      .wdata(wdata[g]),
      .head (head[g]),
      .full (full[g]),
      .empty(empty[g]),
      .drop (drop[g])
    );
  end

  // Search starts one past the last winner, so the last winner has lowest priority.
  function automatic ch_idx_t pick(input ch_idx_t last, input logic [NUM_CH-1:0] ready);
    ch_idx_t c1;
    ch_idx_t c2;
    c1 = rr_next(last);
    c2 = rr_next(c1);
    if (ready[c1])      return c1;
    else if (ready[c2]) return c2;
    else                return last;
  endfunction

  assign grant = pick(rr, ~empty);
  assign load  = (!vld_p0 || mem_ready) && !(&empty);

  always_comb begin
    pop = '0;
    if (load) pop[grant] = 1'b1;
  end

  // Output register stage p0: holds the granted entry until the memory takes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p0   <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      rr       <= 2'd2;
      overflow <= '0;
    end else begin
      overflow <= overflow | drop;
      if (load) begin
        vld_p0   <= 1'b1;
        addr_p0  <= {grant, head[grant].addr};
        wdata_p0 <= head[grant].data;
        rr       <= grant;
      end else if (mem_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign mem_we    = vld_p0;
  assign mem_addr  = addr_p0;
  assign mem_wdata = wdata_p0;
  assign fifo_full = full;
  assign idle      = (&empty) && !vld_p0;
endmodule

// File: tb/tb_result_wb_arbiter.sv
// Scoreboard bench for result_wb_arbiter: queue-based reference model plus directed and random stimulus.
module tb_result_wb_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int NUM_CH = 3;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              in_we_0, in_we_1, in_we_2;
  logic [ADDR_W-1:0] in_addr_0, in_addr_1, in_addr_2;
  logic [DATA_W-1:0] in_data_0, in_data_1, in_data_2;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W+1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] overflow;
  logic              idle;

  result_wb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_we_0(in_we_0), .in_we_1(in_we_1), .in_we_2(in_we_2),
    .in_addr_0(in_addr_0), .in_addr_1(in_addr_1), .in_addr_2(in_addr_2),
    .in_data_0(in_data_0), .in_data_1(in_data_1), .in_data_2(in_data_2),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .fifo_full(fifo_full), .overflow(overflow), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: one queue per channel, a single output slot, and the last winner.
  logic [23:0] mq [NUM_CH][$];
  logic [25:0] exp_q [$];
  bit          slot_v;
  int          rr_m;
  bit [2:0]    ovf_m;
  int          cyc = 0;

  always @(posedge clk) begin
    bit          we_a [NUM_CH];
    logic [23:0] it_a [NUM_CH];
    bit          found;
    int          g;
    logic [23:0] item;
    cyc++;
    we_a[0] = in_we_0; it_a[0] = {in_addr_0, in_data_0};
    we_a[1] = in_we_1; it_a[1] = {in_addr_1, in_data_1};
    we_a[2] = in_we_2; it_a[2] = {in_addr_2, in_data_2};
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      exp_q.delete();
      slot_v = 0;
      rr_m   = 2;
      ovf_m  = '0;
    end else begin
      if (!slot_v || mem_ready) begin
        slot_v = 0;
        found  = 0;
        g      = 0;
        for (int k = 1; k <= 3; k++) begin
          if (!found && mq[(rr_m + k) % 3].size() > 0) begin
            found = 1;
            g     = (rr_m + k) % 3;
          end
        end
        if (found) begin
          item   = mq[g].pop_front();
          slot_v = 1;
          rr_m   = g;
          exp_q.push_back({g[1:0], item});
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (we_a[c]) begin
          if (mq[c].size() < DEPTH) mq[c].push_back(it_a[c]);
          else ovf_m[c] = 1'b1;
        end
      end
    end
  end

  // Monitor: compares the presented write and status against the model every cycle.
  bit mon_en = 0;
  int wr_cnt = 0;
  int ch1_hs = 0;

  always @(negedge clk) begin
    logic [2:0] ff_m;
    bit         idle_m;
    if (mon_en) begin
      for (int c = 0; c < NUM_CH; c++) ff_m[c] = (mq[c].size() == DEPTH);
      idle_m = !slot_v && mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0;
      chk("mem_we", mem_we, slot_v);
      chk("fifo_full", fifo_full, ff_m);
      chk("overflow", overflow, ovf_m);
      chk("idle", idle, idle_m);
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write actual=%0h required=none", {mem_addr, mem_wdata});
        end else begin
          chk("write", {mem_addr, mem_wdata}, exp_q[0]);
        end
        if (mem_ready && rst) begin
          wr_cnt++;
          if (mem_addr[17:16] == 2'd1) ch1_hs = cyc + 1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_we_0 = 0; in_we_1 = 0; in_we_2 = 0;
    in_addr_0 = '0; in_addr_1 = '0; in_addr_2 = '0;
    in_data_0 = '0; in_data_1 = '0; in_data_2 = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 0;
    step();
    rst = 1;
  endtask

  initial begin
    int w0;
    int p;
    clear_in();
    mem_ready = 1;
    rst = 0;
    step();
    step();
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 18'h0);
    chk("rst_mem_wdata", mem_wdata, 8'h0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_overflow", overflow, 3'b000);
    chk("rst_fifo_full", fifo_full, 3'b000);
    rst = 1;
    mon_en = 1;

    // Single result on ch1: two-edge latency, one write cycle.
    in_we_1 = 1; in_addr_1 = 16'h0005; in_data_1 = 8'hA7;
    step();
    clear_in();
    chk("single_lat1", mem_we, 1'b0);
    step();
    chk("single_we", mem_we, 1'b1);
    chk("single_addr", mem_addr, 18'h10005);
    chk("single_data", mem_wdata, 8'hA7);
    step();
    chk("single_done", mem_we, 1'b0);
    chk("single_idle", idle, 1'b1);

    // All three channels on one edge drain as ch0, ch1, ch2.
    do_reset();
    in_we_0 = 1; in_we_1 = 1; in_we_2 = 1;
    in_addr_0 = 16'h0010; in_addr_1 = 16'h0010; in_addr_2 = 16'h0010;
    in_data_0 = 8'h11; in_data_1 = 8'h22; in_data_2 = 8'h33;
    step();
    clear_in();
    step();
    chk("sim_a0", {mem_we, mem_addr, mem_wdata}, {1'b1, 18'h00010, 8'h11});
    step();
    chk("sim_a1", {mem_we, mem_addr, mem_wdata}, {1'b1, 18'h10010, 8'h22});
    step();
    chk("sim_a2", {mem_we, mem_addr, mem_wdata}, {1'b1, 18'h20010, 8'h33});
    step();
    chk("sim_end", mem_we, 1'b0);

    // Back-pressure: held stable for six stalled cycles.
    mem_ready = 0;
    in_we_0 = 1; in_addr_0 = 16'h1234; in_data_0 = 8'h5A;
    step();
    clear_in();
    step();
    for (int i = 0; i < 6; i++) begin
      chk("bp_hold", {mem_we, mem_addr, mem_wdata}, {1'b1, 18'h01234, 8'h5A});
      step();
    end
    w0 = wr_cnt;
    mem_ready = 1;
    step();
    chk("bp_release", mem_we, 1'b0);
    chk("bp_count", wr_cnt - w0, 1);

    // Overflow on ch2: five accepted while stalled, sixth dropped.
    mem_ready = 0;
    for (int i = 0; i < 6; i++) begin
      in_we_2 = 1; in_addr_2 = 16'(16'h0100 + i); in_data_2 = 8'(8'h80 + i);
      step();
      if (i == 4) begin
        chk("ovf_full", fifo_full[2], 1'b1);
        chk("ovf_not_yet", overflow[2], 1'b0);
      end
    end
    clear_in();
    chk("ovf_set", overflow[2], 1'b1);
    w0 = wr_cnt;
    mem_ready = 1;
    repeat (8) step();
    chk("ovf_writes", wr_cnt - w0, 5);
    chk("ovf_sticky", overflow[2], 1'b1);

    // Fairness: ch0 floods, one ch1 entry still gets through promptly.
    do_reset();
    mem_ready = 1;
    p = 0;
    for (int i = 0; i < 16; i++) begin
      in_we_0 = 1; in_addr_0 = 16'(i); in_data_0 = 8'(i);
      in_we_1 = (i == 5); in_addr_1 = 16'h0AAA; in_data_1 = 8'hC1;
      step();
      if (i == 5) p = cyc;
    end
    clear_in();
    repeat (8) step();
    chk("fair_served", (ch1_hs > p) && (ch1_hs - p <= 3), 1'b1);

    // Reset while a write is pending and FIFOs hold data.
    mem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      in_we_0 = 1; in_we_1 = 1; in_we_2 = 1;
      in_data_0 = 8'(i); in_data_1 = 8'(i + 4); in_data_2 = 8'(i + 8);
      step();
    end
    clear_in();
    step();
    chk("mid_pending", mem_we, 1'b1);
    rst = 0;
    step();
    rst = 1;
    chk("mid_we", mem_we, 1'b0);
    chk("mid_addr", mem_addr, 18'h0);
    chk("mid_ovf", overflow, 3'b000);
    chk("mid_idle", idle, 1'b1);
    w0 = wr_cnt;
    mem_ready = 1;
    repeat (5) step();
    chk("mid_no_stale", wr_cnt - w0, 0);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 2000; i++) begin
      in_we_0 = ($urandom_range(0, 9) < 4);
      in_we_1 = ($urandom_range(0, 9) < 3);
      in_we_2 = ($urandom_range(0, 9) < 4);
      in_addr_0 = 16'($urandom); in_addr_1 = 16'($urandom); in_addr_2 = 16'($urandom);
      in_data_0 = 8'($urandom);  in_data_1 = 8'($urandom);  in_data_2 = 8'($urandom);
      mem_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    clear_in();
    mem_ready = 1;
    repeat (20) step();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", idle, 1'b1);

    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
